// File: rtl/fir_pkg.sv
//==============================================================================
// Module : fir_pkg
// Brief  : Shared types and helpers for the time-multiplexed FIR scheduler.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_t;

    // Width that holds N_TAPS full-precision products without overflow.
    function automatic int acc_width(input int data_w, input int coeff_w, input int n_taps);
        return data_w + coeff_w + $clog2(n_taps);
    endfunction

    function automatic int default_coef(input int k);
        return k + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fir_rr_arbiter.sv
//==============================================================================
// Module : fir_rr_arbiter
// Brief  : Round-robin arbiter; search starts one past the last granted index.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req_i,
    input  logic                    en_i,
    output logic                    gnt_valid_o,
    output logic [N_CH-1:0]         gnt_oh_o,
    output logic [$clog2(N_CH)-1:0] gnt_idx_o
);

    localparam int IDX_W = $clog2(N_CH);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = IDX_W'((int'(last_q) + i) % N_CH);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    assign gnt_valid_o = en_i && found;
    assign gnt_oh_o    = gnt_valid_o ? (N_CH'(1) << idx) : '0;
    assign gnt_idx_o   = idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= IDX_W'(N_CH - 1);
        end else if (gnt_valid_o) begin
            last_q <= idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
//==============================================================================
// Module : fir_mac_scheduler
// Brief  : Shares one signed MAC among N_CH FIR channels, round-robin.
//          Define FIR_SAT_EN to saturate results instead of wrapping them.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fir_mac_scheduler
    import fir_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int N_TAPS      = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            in_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] in_data,
    output logic [N_CH-1:0]            in_ready,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic [COEFF_WIDTH-1:0]     coef_wdata,
    output logic                       coef_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(N_CH)-1:0]    out_ch,
    output logic                       busy
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int TAP_W  = $clog2(N_TAPS);
    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
    localparam int ACC_W  = acc_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);

    fir_state_t                    state_q, state_d;
    logic [N_CH-1:0]               pending_q, pending_d;
    logic signed [DATA_WIDTH-1:0]  sample_q [N_CH];
    logic signed [DATA_WIDTH-1:0]  sample_d [N_CH];
    logic signed [DATA_WIDTH-1:0]  hist_q [N_CH][N_TAPS];
    logic signed [DATA_WIDTH-1:0]  hist_d [N_CH][N_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_q [N_TAPS];
    logic signed [COEFF_WIDTH-1:0] coef_d [N_TAPS];
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [TAP_W-1:0]              tap_q, tap_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
    logic [CH_W-1:0]               out_ch_q, out_ch_d;

    logic                          grant_valid;
    logic [N_CH-1:0]               grant_oh;
    logic [CH_W-1:0]               grant_idx;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       sum;
    logic [DATA_WIDTH-1:0]         result;

    fir_rr_arbiter #(
        .N_CH        (N_CH)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (pending_q),
        .en_i        (state_q == IDLE),
        .gnt_valid_o (grant_valid),
        .gnt_oh_o    (grant_oh),
        .gnt_idx_o   (grant_idx)
    );

    assign prod = PROD_W'(hist_q[ch_q][tap_q]) * PROD_W'(coef_q[tap_q]);
    assign sum  = acc_q + ACC_W'(prod);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        if (sum > SAT_MAX) begin
            result = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sum < SAT_MIN) begin
            result = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            result = sum[DATA_WIDTH-1:0];
        end
    end
`else
    assign result = sum[DATA_WIDTH-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        sample_d   = sample_q;
        hist_d     = hist_q;
        coef_d     = coef_q;
        acc_d      = acc_q;
        tap_d      = tap_q;
        ch_d       = ch_q;
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;

        // A busy slot cannot be overwritten, so in_valid is ignored there.
        for (int c = 0; c < N_CH; c++) begin
            if (in_valid[c] && !pending_q[c]) begin
                pending_d[c] = 1'b1;
                sample_d[c]  = in_data[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        if (coef_we && state_q != MAC) begin
            coef_d[coef_addr] = coef_wdata;
        end

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    for (int k = N_TAPS - 1; k > 0; k--) begin
                        hist_d[grant_idx][k] = hist_q[grant_idx][k-1];
                    end
                    hist_d[grant_idx][0] = sample_q[grant_idx];
                    pending_d = pending_d & ~grant_oh;
                    acc_d     = '0;
                    tap_d     = '0;
                    ch_d      = grant_idx;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                tap_d = tap_q + 1'b1;
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    out_data_d = result;
                    out_ch_d   = ch_q;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            acc_q      <= '0;
            tap_q      <= '0;
            ch_q       <= '0;
            out_data_q <= '0;
            out_ch_q   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                sample_q[c] <= '0;
                for (int k = 0; k < N_TAPS; k++) begin
                    hist_q[c][k] <= '0;
                end
            end
            for (int k = 0; k < N_TAPS; k++) begin
                coef_q[k] <= COEFF_WIDTH'(default_coef(k));
            end
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            sample_q   <= sample_d;
            hist_q     <= hist_d;
            coef_q     <= coef_d;
            acc_q      <= acc_d;
            tap_q      <= tap_d;
            ch_q       <= ch_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
        end
    end

    assign in_ready   = ~pending_q;
    assign coef_ready = (state_q != MAC);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;

endmodule

`default_nettype wire
